// File: rtl/piece_pkg.sv
// piece_pkg: shared types, pattern table and helpers
// for the tetromino source.
package piece_pkg;

  typedef enum logic [2:0] {
    P_I = 3'd0,
    P_O = 3'd1,
    P_S = 3'd2,
    P_Z = 3'd3,
    P_L = 3'd4,
    P_J = 3'd5,
    P_T = 3'd6
  } piece_t;

  typedef logic [3:0][3:0] pattern_t;

  typedef enum logic {
    ST_FILL  = 1'b0,
    ST_READY = 1'b1
  } state_t;

  localparam logic [15:0] LFSR_MASK = 16'hB400;

  // Rotation-0 occupancy, [row][col], one entry per type.
  // Slot 7 is unreachable and mirrors I so every index is defined.
  localparam logic [7:0][15:0] ROT0_TBL = {
    16'h2222,
    16'h00E4,
    16'h0644,
    16'h0622,
    16'h00C6,
    16'h006C,
    16'h0066,
    16'h2222
  };

  // One quarter turn clockwise: (r,c) -> (c,3-r).
  function automatic pattern_t rot90(pattern_t p);
    pattern_t q;
    q = '0;
    for (int r = 0; r < 4; r++) begin
      for (int c = 0; c < 4; c++) begin
        q[c][3-r] = p[r][c];
      end
    end
    return q;
  endfunction

  // Galois right-shift step.
  function automatic logic [15:0] lfsr_step(logic [15:0] s);
    return {1'b0, s[15:1]} ^ (s[0] ? LFSR_MASK : 16'h0000);
  endfunction

  // First unused bag slot at or after the candidate, wrapping 6->0.
  function automatic logic [2:0] bag_pick(
    logic [6:0] mask,
    logic [2:0] seed
  );
    logic [2:0] idx;
    logic [2:0] pick;
    logic       found;
    idx   = (seed == 3'd7) ? 3'd0 : seed;
    pick  = idx;
    found = 1'b0;
    for (int i = 0; i < 7; i++) begin
      if (!found && !mask[idx]) begin
        pick  = idx;
        found = 1'b1;
      end
      idx = (idx == 3'd6) ? 3'd0 : idx + 3'd1;
    end
    return pick;
  endfunction

endpackage

// File: rtl/piece_rotator.sv
// piece_rotator: 4x4 occupancy of a piece type at a
// given quarter-turn rotation.
module piece_rotator
  import piece_pkg::*;
(
  input  piece_t     type_i,
  input  logic [1:0] rot_i,
  output pattern_t   pattern_o
);

  pattern_t base;
  pattern_t r1;
  pattern_t r2;
  pattern_t r3;

  // Select the rotated table entry; O is rotation-invariant.
  always_comb begin
    base = ROT0_TBL[type_i];
    r1   = rot90(base);
    r2   = rot90(r1);
    r3   = rot90(r2);
    pattern_o = base;
    if (type_i != P_O) begin
      unique case (rot_i)
        2'd0: pattern_o = base;
        2'd1: pattern_o = r1;
        2'd2: pattern_o = r2;
        2'd3: pattern_o = r3;
      endcase
    end
  end

endmodule

// File: rtl/piece_gen.sv
// piece_gen: 7-bag randomised tetromino source with
// preview queue and rotation state.
module piece_gen
  import piece_pkg::*;
#(
  parameter int          PREVIEW_DEPTH = 3,
  parameter logic [15:0] LFSR_SEED     = 16'hACE1
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          spawn_req,
  input  logic                          rotate_cw,
  input  logic                          rotate_ccw,
  output logic                          ready,
  output logic                          spawn_valid,
  output logic [2:0]                    cur_type,
  output logic [1:0]                    cur_rot,
  output pattern_t                      cur_pattern,
  output pattern_t                      cw_pattern,
  output pattern_t                      ccw_pattern,
  output logic [PREVIEW_DEPTH-1:0][2:0] preview_types
);

  // An all-zero LFSR would lock up.
  localparam logic [15:0] SEED =
    (LFSR_SEED == 16'h0000) ? 16'h0001 : LFSR_SEED;

  localparam logic [2:0] LAST = 3'(PREVIEW_DEPTH);

  state_t                       state_q;
  logic [2:0]                   fill_cnt_q;
  logic [15:0]                  lfsr_q;
  logic [6:0]                   bag_q;
  piece_t                       cur_q;
  logic [1:0]                   rot_q;
  logic [PREVIEW_DEPTH-1:0][2:0] prev_q;
  logic                         ready_q;
  logic                         spawn_valid_q;

  logic [2:0] draw;
  logic [6:0] bag_set;
  logic [6:0] bag_d;
  logic       spawn_go;
  logic       take;
  logic [1:0] rot_cw;
  logic [1:0] rot_ccw;

  assign draw     = bag_pick(bag_q, lfsr_q[2:0]);
  assign bag_set  = bag_q | (7'd1 << draw);
  assign bag_d    = (bag_set == 7'h7F) ? 7'h00 : bag_set;
  assign spawn_go = (state_q == ST_READY) && spawn_req;
  assign take     = (state_q == ST_FILL) || spawn_go;

  // Fill sequencing, spawn shifting, bag and rotation state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= ST_FILL;
      fill_cnt_q    <= 3'd0;
      lfsr_q        <= SEED;
      bag_q         <= 7'h00;
      cur_q         <= P_I;
      rot_q         <= 2'd0;
      prev_q        <= '0;
      ready_q       <= 1'b0;
      spawn_valid_q <= 1'b0;
    end else begin
      lfsr_q        <= lfsr_step(lfsr_q);
      spawn_valid_q <= 1'b0;
      if (take) begin
        bag_q <= bag_d;
      end
      unique case (state_q)
        ST_FILL: begin
          if (fill_cnt_q == 3'd0) begin
            cur_q <= piece_t'(draw);
          end
          for (int i = 0; i < PREVIEW_DEPTH; i++) begin
            if (32'(fill_cnt_q) == i + 1) begin
              prev_q[i] <= draw;
            end
          end
          fill_cnt_q <= fill_cnt_q + 3'd1;
          if (fill_cnt_q == LAST) begin
            state_q <= ST_READY;
            ready_q <= 1'b1;
          end
        end
        ST_READY: begin
          if (spawn_req) begin
            cur_q <= piece_t'(prev_q[0]);
            for (int i = 0; i < PREVIEW_DEPTH - 1; i++) begin
              prev_q[i] <= prev_q[i+1];
            end
            prev_q[PREVIEW_DEPTH-1] <= draw;
            spawn_valid_q <= 1'b1;
          end
        end
        default: ;
      endcase
      if (spawn_go) begin
        rot_q <= 2'd0;
      end else if (rotate_cw && !rotate_ccw) begin
        rot_q <= rot_q + 2'd1;
      end else if (rotate_ccw && !rotate_cw) begin
        rot_q <= rot_q - 2'd1;
      end
    end
  end

  assign rot_cw  = rot_q + 2'd1;
  assign rot_ccw = rot_q - 2'd1;

  piece_rotator u_cur (
    .type_i    (cur_q),
    .rot_i     (rot_q),
    .pattern_o (cur_pattern)
  );

  piece_rotator u_cw (
    .type_i    (cur_q),
    .rot_i     (rot_cw),
    .pattern_o (cw_pattern)
  );

  piece_rotator u_ccw (
    .type_i    (cur_q),
    .rot_i     (rot_ccw),
    .pattern_o (ccw_pattern)
  );

  assign ready         = ready_q;
  assign spawn_valid   = spawn_valid_q;
  assign cur_type      = cur_q;
  assign cur_rot       = rot_q;
  assign preview_types = prev_q;

endmodule

// File: tb/tb_piece_gen.sv
// tb_piece_gen: queue/bag model plus directed rotation,
// spawn and reset checks for piece_gen.
`timescale 1ns/1ps
module tb_piece_gen;

  localparam int D = 3;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic spawn_req = 1'b0;
  logic rotate_cw = 1'b0;
  logic rotate_ccw = 1'b0;
  logic ready;
  logic spawn_valid;
  logic [2:0] cur_type;
  logic [1:0] cur_rot;
  logic [15:0] cur_pattern;
  logic [15:0] cw_pattern;
  logic [15:0] ccw_pattern;
  logic [D-1:0][2:0] preview_types;

  int n_chk = 0;
  int n_fail = 0;

  piece_gen #(
    .PREVIEW_DEPTH (D),
    .LFSR_SEED     (16'hACE1)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .spawn_req     (spawn_req),
    .rotate_cw     (rotate_cw),
    .rotate_ccw    (rotate_ccw),
    .ready         (ready),
    .spawn_valid   (spawn_valid),
    .cur_type      (cur_type),
    .cur_rot       (cur_rot),
    .cur_pattern   (cur_pattern),
    .cw_pattern    (cw_pattern),
    .ccw_pattern   (ccw_pattern),
    .preview_types (preview_types)
  );

  always #5 clk = ~clk;

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // ---- behavioural model ----
  logic [15:0] m_lfsr;
  bit          m_used[7];
  int          m_cur;
  int          m_rot;
  int          m_cnt;
  int          m_prev[D];
  bit          m_ready;
  bit          m_sv;

  function automatic logic [15:0] model_pat(int t, int k);
    int rr[4];
    int cc[4];
    int r;
    int c;
    int tmp;
    logic [15:0] p;
    case (t)
      1: begin rr = '{0,0,1,1}; cc = '{1,2,1,2}; end
      2: begin rr = '{0,0,1,1}; cc = '{2,3,1,2}; end
      3: begin rr = '{0,0,1,1}; cc = '{1,2,2,3}; end
      4: begin rr = '{0,1,2,2}; cc = '{1,1,1,2}; end
      5: begin rr = '{0,1,2,2}; cc = '{2,2,2,1}; end
      6: begin rr = '{0,1,1,1}; cc = '{2,1,2,3}; end
      default: begin rr = '{0,1,2,3}; cc = '{1,1,1,1}; end
    endcase
    if (t == 1) k = 0;
    p = '0;
    for (int i = 0; i < 4; i++) begin
      r = rr[i];
      c = cc[i];
      for (int j = 0; j < k; j++) begin
        tmp = r;
        r = c;
        c = 3 - tmp;
      end
      p[r*4+c] = 1'b1;
    end
    return p;
  endfunction

  task automatic model_reset();
    m_lfsr = 16'hACE1;
    m_cur = 0;
    m_rot = 0;
    m_cnt = 0;
    m_ready = 0;
    m_sv = 0;
    for (int i = 0; i < D; i++) m_prev[i] = 0;
    for (int i = 0; i < 7; i++) m_used[i] = 0;
  endtask

  task automatic model_draw(output int d);
    int cand;
    int idx;
    bit full;
    cand = int'(m_lfsr[2:0]);
    if (cand == 7) cand = 0;
    d = -1;
    for (int i = 0; i < 7; i++) begin
      idx = (cand + i) % 7;
      if (d < 0 && !m_used[idx]) d = idx;
    end
    m_used[d] = 1;
    full = 1;
    for (int i = 0; i < 7; i++) if (!m_used[i]) full = 0;
    if (full) for (int i = 0; i < 7; i++) m_used[i] = 0;
  endtask

  task automatic model_clock(bit sp, bit cw, bit ccw);
    int d;
    bit spawn;
    spawn = m_ready && sp;
    m_sv = spawn;
    if (!m_ready) begin
      model_draw(d);
      if (m_cnt == 0) m_cur = d;
      else m_prev[m_cnt-1] = d;
      m_cnt++;
      if (m_cnt == D + 1) m_ready = 1;
    end else if (spawn) begin
      model_draw(d);
      m_cur = m_prev[0];
      for (int i = 0; i < D - 1; i++) m_prev[i] = m_prev[i+1];
      m_prev[D-1] = d;
      m_rot = 0;
    end
    if (!spawn) begin
      if (cw && !ccw) m_rot = (m_rot + 1) % 4;
      else if (ccw && !cw) m_rot = (m_rot + 3) % 4;
    end
    m_lfsr = {1'b0, m_lfsr[15:1]} ^ (m_lfsr[0] ? 16'hB400 : 16'h0000);
  endtask

  initial begin
    model_reset();
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) model_reset();
      else model_clock(spawn_req, rotate_cw, rotate_ccw);
    end
  end

  // ---- per-cycle compare ----
  always @(negedge clk) begin
    check("ready", ready, m_ready);
    check("spawn_valid", spawn_valid, m_sv);
    check("cur_type", cur_type, m_cur);
    check("cur_rot", cur_rot, m_rot);
    for (int i = 0; i < D; i++)
      check($sformatf("preview%0d", i), preview_types[i], m_prev[i]);
    check("cur_pattern", cur_pattern, model_pat(m_cur, m_rot));
    check("cw_pattern", cw_pattern, model_pat(m_cur, (m_rot + 1) % 4));
    check("ccw_pattern", ccw_pattern, model_pat(m_cur, (m_rot + 3) % 4));
  end

  // ---- directed stimulus ----
  int seq_b[14];
  int seq_c[14];

  task automatic run_seq(output int s[14], input bit mid_reset);
    @(negedge clk);
    #2 rst_n = 1'b0;
    spawn_req = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    spawn_req = 1'b1;
    repeat (4) @(negedge clk);
    check("seq_ready", ready, 1);
    s[0] = int'(cur_type);
    for (int i = 1; i < 14; i++) begin
      @(negedge clk);
      check("seq_spawn_valid", spawn_valid, 1);
      s[i] = int'(cur_type);
    end
    if (mid_reset) begin
      #3 rst_n = 1'b0;
      #1;
      check("async_ready", ready, 0);
      check("async_spawn_valid", spawn_valid, 0);
      check("async_cur_type", cur_type, 0);
      check("async_cur_rot", cur_rot, 0);
      check("async_preview", preview_types, 0);
    end
    spawn_req = 1'b0;
  endtask

  function automatic logic [6:0] perm_mask(int s[14], int base);
    logic [6:0] m;
    m = '0;
    for (int i = 0; i < 7; i++) m[s[base+i]] = 1'b1;
    return m;
  endfunction

  initial begin
    int exp_next;
    bit found;

    repeat (2) @(negedge clk);
    check("rst_ready", ready, 0);
    check("rst_cur_type", cur_type, 0);
    check("rst_preview", preview_types, 0);

    // Fill with spawn_req held; it must be ignored.
    spawn_req = 1'b1;
    rst_n = 1'b1;
    repeat (3) begin
      @(negedge clk);
      check("fill_ready_low", ready, 0);
      check("fill_no_spawn", spawn_valid, 0);
    end
    @(negedge clk);
    check("fill_ready_high", ready, 1);
    check("fill_cur", cur_type, 1);
    check("fill_prev0", preview_types[0], 0);
    check("fill_prev1", preview_types[1], 2);
    check("fill_prev2", preview_types[2], 4);

    // First spawn makes I current.
    @(negedge clk);
    spawn_req = 1'b0;
    check("spawn1_valid", spawn_valid, 1);
    check("spawn1_type", cur_type, 0);
    rotate_cw = 1'b1;
    @(negedge clk);
    rotate_cw = 1'b0;
    check("I_rot", cur_rot, 1);
    check("I_cur_pat", cur_pattern, 16'h00F0);
    check("I_ccw_pat", ccw_pattern, 16'h2222);
    check("I_cw_pat", cw_pattern, 16'h4444);

    // Spawn until T is current.
    found = 0;
    for (int i = 0; i < 30 && !found; i++) begin
      if (cur_type == 3'd6) begin
        found = 1;
      end else begin
        spawn_req = 1'b1;
        @(negedge clk);
        spawn_req = 1'b0;
      end
    end
    check("find_T", found, 1);
    rotate_cw = 1'b1;
    @(negedge clk);
    rotate_cw = 1'b0;
    check("T_rot", cur_rot, 1);
    check("T_cur_pat", cur_pattern, 16'h4C40);
    rotate_cw = 1'b1;
    rotate_ccw = 1'b1;
    @(negedge clk);
    rotate_cw = 1'b0;
    rotate_ccw = 1'b0;
    check("both_rot", cur_rot, 1);
    rotate_cw = 1'b1;
    @(negedge clk);
    check("T_rot2", cur_rot, 2);

    // Spawn beats a simultaneous rotate.
    exp_next = m_prev[0];
    spawn_req = 1'b1;
    @(negedge clk);
    spawn_req = 1'b0;
    rotate_cw = 1'b0;
    check("spawn_rot_zero", cur_rot, 0);
    check("spawn_rot_type", cur_type, exp_next);
    check("spawn_rot_valid", spawn_valid, 1);

    // Two runs from reset must give the same bag sequence.
    run_seq(seq_b, 1'b1);
    check("seqB_first", seq_b[0], 1);
    check("seqB_perm0", perm_mask(seq_b, 0), 7'h7F);
    check("seqB_perm1", perm_mask(seq_b, 7), 7'h7F);
    run_seq(seq_c, 1'b0);
    for (int i = 0; i < 14; i++)
      check($sformatf("repeat%0d", i), seq_c[i], seq_b[i]);

    @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

endmodule
